// File: rtl/dmem_channel_arbiter.sv
// dmem_channel_arbiter: round-robin sharing of NUM_CHANNELS data-memory
// channels between NUM_CONSUMERS LSUs. Each channel runs its own small FSM;
// at most one consumer is granted per cycle.
//
// state       | meaning
// IDLE        | channel free, may take a grant
// READ_WAIT   | mem_read_valid high, waiting for mem_read_ready
// READ_RELAY  | read data held on the owner until it drops read_valid
// WRITE_WAIT  | mem_write_valid high, waiting for mem_write_ready
// WRITE_RELAY | write done held on the owner until it drops write_valid
module dmem_channel_arbiter #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 4
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]                 mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                 mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]                 mem_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                 mem_write_ready
);

  localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    READ_WAIT   = 3'd1,
    READ_RELAY  = 3'd2,
    WRITE_WAIT  = 3'd3,
    WRITE_RELAY = 3'd4
  } chan_state_t;

  chan_state_t state   [NUM_CHANNELS];
  chan_state_t state_n [NUM_CHANNELS];
  logic [CW-1:0] owner   [NUM_CHANNELS];
  logic [CW-1:0] owner_n [NUM_CHANNELS];

  logic [CW-1:0]            rr_ptr, rr_ptr_n;
  logic [NUM_CONSUMERS-1:0] busy, busy_n;

  logic [NUM_CONSUMERS-1:0]                crr_n;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] crd_n;
  logic [NUM_CONSUMERS-1:0]                cwr_n;
  logic [NUM_CHANNELS-1:0]                 mrv_n;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mra_n;
  logic [NUM_CHANNELS-1:0]                 mwv_n;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mwa_n;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mwd_n;

  logic [NUM_CONSUMERS-1:0] eligible;
  logic [NUM_CHANNELS-1:0]  grant_sel;
  logic [CW-1:0]            grant_con;
  logic [CW-1:0]            idx;
  logic                     found_ch, found_con, grant_valid;

  // Grant selection: lowest-index idle channel, first eligible consumer from rr_ptr.
  always_comb begin
    eligible    = (consumer_read_valid | consumer_write_valid) & ~busy;
    grant_sel   = '0;
    grant_con   = '0;
    idx         = '0;
    found_ch    = 1'b0;
    found_con   = 1'b0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (!found_ch && state[ch] == IDLE) begin
        found_ch      = 1'b1;
        grant_sel[ch] = 1'b1;
      end
    end
    // NUM_CONSUMERS is a power of two, so the CW-bit add wraps naturally.
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      idx = rr_ptr + i[CW-1:0];
      if (!found_con && eligible[idx]) begin
        found_con = 1'b1;
        grant_con = idx;
      end
    end
    grant_valid = found_ch & found_con;
  end

  // Next-state and output logic for every channel FSM plus shared arbiter state.
  always_comb begin
    rr_ptr_n = rr_ptr;
    busy_n   = busy;
    crr_n    = consumer_read_ready;
    crd_n    = consumer_read_data;
    cwr_n    = consumer_write_ready;
    mrv_n    = mem_read_valid;
    mra_n    = mem_read_address;
    mwv_n    = mem_write_valid;
    mwa_n    = mem_write_address;
    mwd_n    = mem_write_data;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      state_n[ch] = state[ch];
      owner_n[ch] = owner[ch];
    end

    // Non-idle channels always have distinct owners, so the indexed
    // consumer updates below never collide.
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      case (state[ch])
        IDLE: begin
          if (grant_valid && grant_sel[ch]) begin
            owner_n[ch] = grant_con;
            if (consumer_read_valid[grant_con]) begin
              state_n[ch] = READ_WAIT;
              mrv_n[ch]   = 1'b1;
              mra_n[ch]   = consumer_read_address[grant_con];
            end else begin
              state_n[ch] = WRITE_WAIT;
              mwv_n[ch]   = 1'b1;
              mwa_n[ch]   = consumer_write_address[grant_con];
              mwd_n[ch]   = consumer_write_data[grant_con];
            end
          end
        end
        READ_WAIT: begin
          if (mem_read_ready[ch]) begin
            mrv_n[ch]        = 1'b0;
            crd_n[owner[ch]] = mem_read_data[ch];
            crr_n[owner[ch]] = 1'b1;
            state_n[ch]      = READ_RELAY;
          end
        end
        READ_RELAY: begin
          if (!consumer_read_valid[owner[ch]]) begin
            crr_n[owner[ch]]  = 1'b0;
            busy_n[owner[ch]] = 1'b0;
            state_n[ch]       = IDLE;
          end
        end
        WRITE_WAIT: begin
          if (mem_write_ready[ch]) begin
            mwv_n[ch]        = 1'b0;
            cwr_n[owner[ch]] = 1'b1;
            state_n[ch]      = WRITE_RELAY;
          end
        end
        WRITE_RELAY: begin
          if (!consumer_write_valid[owner[ch]]) begin
            cwr_n[owner[ch]]  = 1'b0;
            busy_n[owner[ch]] = 1'b0;
            state_n[ch]       = IDLE;
          end
        end
        default: state_n[ch] = IDLE;
      endcase
    end

    // A granted consumer is never the one being released (it was not busy).
    if (grant_valid) begin
      busy_n[grant_con] = 1'b1;
      rr_ptr_n          = grant_con + CW'(1);
    end
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr               <= '0;
      busy                 <= '0;
      consumer_read_ready  <= '0;
      consumer_read_data   <= '0;
      consumer_write_ready <= '0;
      mem_read_valid       <= '0;
      mem_read_address     <= '0;
      mem_write_valid      <= '0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state[ch] <= IDLE;
        owner[ch] <= '0;
      end
    end else begin
      rr_ptr               <= rr_ptr_n;
      busy                 <= busy_n;
      consumer_read_ready  <= crr_n;
      consumer_read_data   <= crd_n;
      consumer_write_ready <= cwr_n;
      mem_read_valid       <= mrv_n;
      mem_read_address     <= mra_n;
      mem_write_valid      <= mwv_n;
      mem_write_address    <= mwa_n;
      mem_write_data       <= mwd_n;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        state[ch] <= state_n[ch];
        owner[ch] <= owner_n[ch];
      end
    end
  end

endmodule
